johnson_sched: RTL and testbench
================================

# johnson_sched

Run controller for the team's synchronous Johnson counter. Takes a start request with a revolution count, clears the counter, then enables it for exactly N full revolutions (2·WIDTH steps each). Supports hold and abort, and reports done, progress and optional pattern-fault status. Sits between the control/CSR logic and a Johnson counter with synchronous clear and enable.

## Interface
- WIDTH, 4: Johnson counter width; one revolution = 2·WIDTH steps (8 at default). Legal range 2..16.
- CW, 8: width of revolution count and progress counter.

- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- start  in  1  run request, sampled only in IDLE, DONE or FAULT
- num_rev  in  CW  revolutions to run, latched on accepted start
- hold  in  1  pauses stepping while high in RUN
- abort  in  1  terminates a run, no done pulse
- jc_out  in  WIDTH  current counter value, fed back for checking
- jc_clr  out  1  counter synchronous clear (counter gives clr priority over en)
- jc_en  out  1  counter step enable
- busy  out  1  high in CLEAR and RUN
- done  out  1  one-cycle pulse at normal completion
- rev_cnt  out  CW  completed revolutions in current/last run
- err  out  1  sticky pattern fault (see Configuration)

## Operation
- Counter sequence, WIDTH=4: 0000→0001→0011→0111→1111→1110→1100→1000→0000 (shift left, insert ~MSB).
- States: IDLE, CLEAR, RUN, DONE, FAULT. Reset → IDLE.
- IDLE/DONE/FAULT + start, num_rev≠0 → CLEAR. Latch num_rev, zero rev_cnt, phase counter and shadow, clear err.
- start with num_rev=0 → DONE directly. done pulses, jc_clr/jc_en stay low, rev_cnt=0.
- CLEAR (exactly 1 cycle): jc_clr=1, jc_en=0 → RUN.
- RUN: jc_en = ~hold & ~abort. Each enabled cycle advances the phase counter (0..2·WIDTH−1) and an internal shadow Johnson register.
  - Phase wrap 2·WIDTH−1→0 increments rev_cnt.
  - When the increment makes rev_cnt == latched num_rev → DONE.
- Hold: jc_en=0, all state frozen, stays in RUN.
- Abort in RUN or CLEAR → IDLE same edge. jc_en=0 in that cycle, no done, rev_cnt keeps its value.
- Abort and final step in the same cycle: abort wins, no step is taken, → IDLE.
- DONE: done=1 for one cycle. Without start → IDLE. With start → CLEAR (back-to-back).
- start while busy is ignored. rst mid-run → IDLE next edge, all outputs 0.
- Arithmetic: rev_cnt saturates by construction (stops at num_rev ≤ 2^CW−1). Phase counter width is clog2(2·WIDTH).

## Timing
- Reset values: jc_clr=0, jc_en=0, busy=0, done=0, rev_cnt=0, err=0.
- All outputs are registered-state-decoded, with one exception: jc_en is combinationally gated by hold/abort.
- Start accepted at edge E0. jc_clr high in cycle E0..E1. First jc_en in cycle E1..E2.
- The counter updates on the same edge as the shadow, so jc_out equals the shadow in every RUN cycle.
- N revolutions with no hold: busy for 1+N·2·WIDTH cycles. done asserts in the cycle after the last jc_en.
- Each hold cycle extends the run by one cycle.

## Configuration
- JSCHED_CHECK_EN defined:
  - In RUN and DONE, jc_out ≠ shadow → FAULT next edge. jc_en=0, busy=0, err=1.
  - err holds until rst or an accepted start.
  - rev_cnt freezes at the fault.
- JSCHED_CHECK_EN undefined:
  - No shadow or compare logic. FAULT state is unreachable.
  - err is tied to 0 and jc_out is ignored.

## Test plan
- Basic run: WIDTH=4, num_rev=2, start at E0 → jc_clr at cycle 1, jc_en high cycles 2–17 (16 steps). jc_out walks 0000→…→1000→0000 twice. done at cycle 18, rev_cnt=2.
- Zero count: num_rev=0 + start → done next cycle. jc_clr/jc_en never assert, busy stays 0.
- Hold: num_rev=1, hold high for 3 cycles mid-run → jc_out frozen during hold, done 3 cycles later than without hold, rev_cnt=1.
- Abort and rst: abort at step 5 of num_rev=3 → IDLE, no done, rev_cnt=0. Repeat with rst at step 5 → all outputs 0 next cycle. Repeat with abort on the final step → no done.
- Back-to-back: start held during DONE with num_rev=1 → CLEAR immediately after the done pulse. rev_cnt resets to 0, then reaches 1.
- Fault (JSCHED_CHECK_EN): counter model forces jc_out=0101 at step 3 → err=1 and jc_en=0 the next cycle. A subsequent start clears err and the run completes normally.

Source files
------------

// File: rtl/johnson_sched.sv
// Run controller for a synchronous Johnson counter: clear, then step for N full revolutions.
// Optional pattern checking against an internal shadow counter is enabled with `define JSCHED_CHECK_EN.
module johnson_sched #(
  parameter int WIDTH = 4,
  parameter int CW    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CW-1:0]    num_rev,
  input  logic             hold,
  input  logic             abort,
  input  logic [WIDTH-1:0] jc_out,
  output logic             jc_clr,
  output logic             jc_en,
  output logic             busy,
  output logic             done,
  output logic [CW-1:0]    rev_cnt,
  output logic             err
);

  localparam int PW = $clog2(2 * WIDTH);
  localparam logic [PW-1:0] PHASE_LAST = PW'(2 * WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_RUN   = 3'd2,
    S_DONE  = 3'd3,
    S_FAULT = 3'd4
  } state_t;

  state_t        state_r;
  logic [PW-1:0] phase_r;
  logic [CW-1:0] num_rev_r;
  logic [CW-1:0] rev_cnt_r;
  logic          err_r;
  logic          fault_s;
  logic          wrap_s;
  logic          last_s;

`ifdef JSCHED_CHECK_EN
  logic [WIDTH-1:0] shadow_r;

  function automatic logic [WIDTH-1:0] jc_next(input logic [WIDTH-1:0] v);
    return {v[WIDTH-2:0], ~v[WIDTH-1]};
  endfunction

  // The real counter must track the shadow whenever it is expected to be stable or stepping.
  always_comb begin
    fault_s = 1'b0;
    if ((state_r == S_RUN) || (state_r == S_DONE)) begin
      fault_s = (jc_out != shadow_r);
    end else begin
      fault_s = 1'b0;
    end
  end
`else
  logic unused_jc_out;
  assign unused_jc_out = ^jc_out;
  assign fault_s       = 1'b0;
`endif

  // Revolution bookkeeping for the current step.
  always_comb begin
    wrap_s = 1'b0;
    last_s = 1'b0;
    if (phase_r == PHASE_LAST) begin
      wrap_s = 1'b1;
      last_s = ((rev_cnt_r + CW'(1)) == num_rev_r);
    end else begin
      wrap_s = 1'b0;
      last_s = 1'b0;
    end
  end

  // Run-control state machine.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= S_IDLE;
      phase_r   <= '0;
      num_rev_r <= '0;
      rev_cnt_r <= '0;
      err_r     <= 1'b0;
`ifdef JSCHED_CHECK_EN
      shadow_r  <= '0;
`endif
    end else begin
      case (state_r)
        S_IDLE, S_DONE, S_FAULT: begin
          if ((state_r == S_DONE) && fault_s) begin
            state_r <= S_FAULT;
            err_r   <= 1'b1;
          end else if (start) begin
            num_rev_r <= num_rev;
            rev_cnt_r <= '0;
            phase_r   <= '0;
            err_r     <= 1'b0;
`ifdef JSCHED_CHECK_EN
            shadow_r  <= '0;
`endif
            state_r   <= (num_rev == '0) ? S_DONE : S_CLEAR;
          end else if (state_r == S_DONE) begin
            state_r <= S_IDLE;
          end else begin
            state_r <= state_r;
          end
        end
        S_CLEAR: begin
          state_r <= abort ? S_IDLE : S_RUN;
        end
        S_RUN: begin
          if (abort) begin
            state_r <= S_IDLE;
          end else if (fault_s) begin
            state_r <= S_FAULT;
            err_r   <= 1'b1;
          end else if (!hold) begin
            phase_r <= wrap_s ? '0 : (phase_r + PW'(1));
`ifdef JSCHED_CHECK_EN
            shadow_r <= jc_next(shadow_r);
`endif
            if (wrap_s) begin
              rev_cnt_r <= rev_cnt_r + CW'(1);
            end
            if (last_s) begin
              state_r <= S_DONE;
            end
          end else begin
            state_r <= S_RUN;
          end
        end
        default: begin
          state_r <= S_IDLE;
        end
      endcase
    end
  end

  assign jc_clr  = (state_r == S_CLEAR);
  assign jc_en   = (state_r == S_RUN) & ~hold & ~abort;
  assign busy    = (state_r == S_CLEAR) || (state_r == S_RUN);
  assign done    = (state_r == S_DONE);
  assign rev_cnt = rev_cnt_r;
  assign err     = err_r;

endmodule

// File: tb/tb_johnson_sched.sv
// Bench for johnson_sched: step-count model plus directed scenarios with hand-computed timing.
// Build with +define+JSCHED_CHECK_EN to also exercise the pattern-fault path.
module tb_johnson_sched;
  localparam int WIDTH = 4;
  localparam int CW    = 8;
  localparam int STEPS = 2 * WIDTH;
`ifdef JSCHED_CHECK_EN
  localparam bit CHECK = 1'b1;
`else
  localparam bit CHECK = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst, start, hold, abort, corrupt;
  logic [CW-1:0]    num_rev;
  logic [WIDTH-1:0] jc_out, jc_q;
  logic             jc_clr, jc_en, busy, done, err;
  logic [CW-1:0]    rev_cnt;

  int total = 0, bad = 0, cyc = 0;

  johnson_sched #(.WIDTH(WIDTH), .CW(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .num_rev(num_rev), .hold(hold), .abort(abort),
    .jc_out(jc_out), .jc_clr(jc_clr), .jc_en(jc_en), .busy(busy), .done(done),
    .rev_cnt(rev_cnt), .err(err)
  );

  always #5 clk = ~clk;

  // Environment Johnson counter; corrupt overrides its visible value.
  always @(posedge clk) begin
    if (rst || jc_clr) jc_q <= '0;
    else if (jc_en) jc_q <= {jc_q[WIDTH-2:0], ~jc_q[WIDTH-1]};
  end
  assign jc_out = corrupt ? 4'b0101 : jc_q;

  always @(posedge clk) cyc <= cyc + 1;

  // Expected counter value after s total steps, from the count of ones in each half-revolution.
  function automatic logic [WIDTH-1:0] pattern(input int s);
    int k;
    k = s % STEPS;
    if (k <= WIDTH) return WIDTH'((1 << k) - 1);
    else return WIDTH'(((1 << WIDTH) - 1) & ~((1 << (k - WIDTH)) - 1));
  endfunction

  // Model: a run is a number of enabled steps; revolutions are steps / STEPS.
  bit m_clear = 1'b0, m_run = 1'b0, m_done = 1'b0, m_err = 1'b0;
  int m_steps = 0, m_total = 0;

  always @(posedge clk) begin : model
    bit c, r, d, e;
    int s, t;
    c = m_clear; r = m_run; d = m_done; e = m_err; s = m_steps; t = m_total;
    if (rst) begin
      c = 1'b0; r = 1'b0; d = 1'b0; e = 1'b0; s = 0; t = 0;
    end else if (r) begin
      if (abort) r = 1'b0;
      else if (CHECK && (jc_out !== pattern(s))) begin r = 1'b0; e = 1'b1; end
      else if (!hold) begin
        s = s + 1;
        if (s == t) begin r = 1'b0; d = 1'b1; end
      end
    end else if (c) begin
      c = 1'b0;
      r = !abort;
    end else if (d && CHECK && (jc_out !== pattern(s))) begin
      d = 1'b0; e = 1'b1;
    end else begin
      d = 1'b0;
      if (start) begin
        e = 1'b0; s = 0; t = int'(num_rev) * STEPS;
        if (num_rev == '0) d = 1'b1; else c = 1'b1;
      end
    end
    m_clear <= c; m_run <= r; m_done <= d; m_err <= e; m_steps <= s; m_total <= t;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d, wanted %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (cyc > 0) begin
      chk("jc_clr", 32'(jc_clr), 32'(m_clear));
      chk("jc_en", 32'(jc_en), 32'(m_run & ~hold & ~abort));
      chk("busy", 32'(busy), 32'(m_clear | m_run));
      chk("done", 32'(done), 32'(m_done));
      chk("rev_cnt", 32'(rev_cnt), 32'(m_steps / STEPS));
      chk("err", 32'(err), 32'(m_err));
      if (m_run && !corrupt) chk("jc_out", 32'(jc_out), 32'(pattern(m_steps)));
    end
  end

  // Per-run timing trackers; t=0 is the cycle in which start is applied.
  bit trk_on = 1'b0;
  int trk_t, done_at, done2_at, clr_at, en_cnt, busy_cnt;

  always @(negedge clk) begin
    if (trk_on) begin
      trk_t++;
      if (done && done_at < 0) done_at = trk_t;
      else if (done && done2_at < 0) done2_at = trk_t;
      if (jc_clr && clr_at < 0) clr_at = trk_t;
      if (jc_en) en_cnt++;
      if (busy) busy_cnt++;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic trk_reset();
    trk_t = -1; done_at = -1; done2_at = -1; clr_at = -1; en_cnt = 0; busy_cnt = 0;
    trk_on = 1'b1;
  endtask

  task automatic begin_run(input int n);
    trk_reset();
    start = 1'b1;
    num_rev = CW'(n);
    tick(1);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int i;
    i = 0;
    while (done_at < 0 && i < budget) begin
      tick(1);
      i++;
    end
    chk("done_seen", 32'(done_at >= 0), 32'd1);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; hold = 1'b0; abort = 1'b0; corrupt = 1'b0; num_rev = '0;
    tick(3);
    rst = 1'b0;
    tick(1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rev", 32'(rev_cnt), 32'd0);

    // Basic: two revolutions.
    begin_run(2);
    wait_done(60);
    chk("basic_done_at", done_at, 32'd18);
    chk("basic_clr_at", clr_at, 32'd1);
    chk("basic_en_cnt", en_cnt, 32'd16);
    chk("basic_busy_cnt", busy_cnt, 32'd17);
    chk("basic_rev", 32'(rev_cnt), 32'd2);
    tick(2);

    // Zero revolutions.
    begin_run(0);
    wait_done(10);
    chk("zero_done_at", done_at, 32'd1);
    chk("zero_busy_cnt", busy_cnt, 32'd0);
    chk("zero_clr_at", clr_at, 32'hFFFF_FFFF);
    chk("zero_en_cnt", en_cnt, 32'd0);
    chk("zero_rev", 32'(rev_cnt), 32'd0);
    tick(2);

    // Hold for three cycles mid-run.
    begin_run(1);
    tick(4);
    hold = 1'b1;
    tick(3);
    hold = 1'b0;
    wait_done(40);
    chk("hold_done_at", done_at, 32'd13);
    chk("hold_en_cnt", en_cnt, 32'd8);
    chk("hold_rev", 32'(rev_cnt), 32'd1);
    tick(2);

    // Abort at step 5 of three revolutions.
    begin_run(3);
    tick(5);
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    tick(5);
    chk("abort_no_done", done_at, 32'hFFFF_FFFF);
    chk("abort_en_cnt", en_cnt, 32'd4);
    chk("abort_rev", 32'(rev_cnt), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);

    // Reset at step 5.
    begin_run(3);
    tick(5);
    rst = 1'b1;
    tick(1);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_en", 32'(jc_en), 32'd0);
    chk("rst_mid_clr", 32'(jc_clr), 32'd0);
    chk("rst_mid_rev", 32'(rev_cnt), 32'd0);
    rst = 1'b0;
    tick(2);

    // Abort on the final step.
    begin_run(1);
    tick(8);
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    tick(4);
    chk("abort_last_no_done", done_at, 32'hFFFF_FFFF);
    chk("abort_last_en_cnt", en_cnt, 32'd7);
    chk("abort_last_rev", 32'(rev_cnt), 32'd0);

    // Back-to-back: start held high through the done pulse.
    trk_reset();
    start = 1'b1;
    num_rev = CW'(1);
    begin
      int i;
      i = 0;
      while (done2_at < 0 && i < 60) begin
        tick(1);
        i++;
      end
    end
    start = 1'b0;
    chk("b2b_done_at", done_at, 32'd10);
    chk("b2b_done2_at", done2_at, 32'd20);
    tick(12);
    chk("b2b_rev", 32'(rev_cnt), 32'd1);

`ifdef JSCHED_CHECK_EN
    // Corrupted counter value at step 3.
    begin_run(2);
    tick(3);
    corrupt = 1'b1;
    tick(1);
    corrupt = 1'b0;
    chk("fault_err", 32'(err), 32'd1);
    chk("fault_en", 32'(jc_en), 32'd0);
    chk("fault_busy", 32'(busy), 32'd0);
    tick(2);
    chk("fault_err_sticky", 32'(err), 32'd1);
    begin_run(1);
    chk("fault_err_cleared", 32'(err), 32'd0);
    wait_done(40);
    chk("fault_rerun_done_at", done_at, 32'd10);
    chk("fault_rerun_rev", 32'(rev_cnt), 32'd1);
    tick(2);
`endif

    trk_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
